warp_scheduler: RTL and testbench

//  Per-core warp scheduler: owns warp_state and PC for WARPS_PER_CORE warps and

---
 rtl/warp_scheduler.sv | 165 ++++++++++++++++
 tb/tb_warp_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_scheduler.sv
// warp_scheduler: owns per-warp state and PC, and round-robin arbitrates the
// single shared ALU/LSU/register-file execution path between the warps.
module warp_scheduler #(
    parameter int WARPS_PER_CORE   = 4,
    parameter int THREADS_PER_WARP = 32,
    parameter int PC_WIDTH         = 12,
    localparam int NW_W  = $clog2(WARPS_PER_CORE + 1),
    localparam int IDX_W = (WARPS_PER_CORE > 1) ? $clog2(WARPS_PER_CORE) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [NW_W-1:0]                    num_warps,
    input  logic [WARPS_PER_CORE-1:0]          fetch_done,
    input  logic [WARPS_PER_CORE-1:0]          decoded_mem,
    input  logic [WARPS_PER_CORE-1:0]          decoded_halt,
    input  logic                               lsu_done,
    input  logic                               branch_taken,
    input  logic [PC_WIDTH-1:0]                branch_target,
    output logic [3*WARPS_PER_CORE-1:0]        warp_state,
    output logic [PC_WIDTH*WARPS_PER_CORE-1:0] pc,
    output logic [IDX_W-1:0]                   current_warp,
    output logic                               current_valid,
    output logic                               done
);

    localparam int unsigned NWARP = WARPS_PER_CORE;

    if (WARPS_PER_CORE < 1 || THREADS_PER_WARP < 1) begin : g_param_check
        $error("warp_scheduler: WARPS_PER_CORE and THREADS_PER_WARP must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_REQUEST = 3'd3,
        S_WAIT    = 3'd4,
        S_EXECUTE = 3'd5,
        S_UPDATE  = 3'd6,
        S_DONE    = 3'd7
    } warp_state_t;

    warp_state_t         state_q [NWARP];
    warp_state_t         state_d [NWARP];
    logic [PC_WIDTH-1:0] pc_q    [NWARP];
    logic [PC_WIDTH-1:0] pc_d    [NWARP];
    logic [IDX_W-1:0]    cur_q, cur_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic                valid_q, valid_d;
    logic                launched_q, launched_d;
    logic                done_q, done_d;

    logic                all_quiet;
    logic                start_ok;
    logic                path_free;
    logic                grant_valid;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    scan_idx;

    // State register: every warp, the path owner and the round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NWARP; i++) begin
                state_q[i] <= S_IDLE;
                pc_q[i]    <= '0;
            end
            cur_q      <= '0;
            rr_q       <= IDX_W'(NWARP - 1);
            valid_q    <= 1'b0;
            launched_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cur_q      <= cur_d;
            rr_q       <= rr_d;
            valid_q    <= valid_d;
            launched_q <= launched_d;
            done_q     <= done_d;
        end
    end

    // Next state: launch, per-warp progression, path arbitration and completion.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cur_d       = cur_q;
        rr_d        = rr_q;
        valid_d     = valid_q;
        launched_d  = launched_q;
        done_d      = done_q;
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;

        all_quiet = 1'b1;
        for (int unsigned i = 0; i < NWARP; i++) begin
            if (state_q[i] != S_IDLE && state_q[i] != S_DONE) all_quiet = 1'b0;
        end
        start_ok  = start && all_quiet;
        path_free = !valid_q || (state_q[cur_q] == S_UPDATE);

        // First requester after the last grant wins; the releasing owner is in
        // UPDATE, never REQUEST, so it cannot win its own handoff.
        if (path_free) begin
            for (int unsigned k = 1; k <= NWARP; k++) begin
                scan_idx = IDX_W'((32'(rr_q) + k) % NWARP);
                if (!grant_valid && state_q[scan_idx] == S_REQUEST) begin
                    grant_valid = 1'b1;
                    grant_idx   = scan_idx;
                end
            end
        end

        if (start_ok) begin
            for (int unsigned i = 0; i < NWARP; i++) begin
                state_d[i] = (i < 32'(num_warps)) ? S_FETCH : S_DONE;
                pc_d[i]    = '0;
            end
            launched_d = 1'b1;
            done_d     = 1'b0;
        end else begin
            for (int unsigned i = 0; i < NWARP; i++) begin
                unique case (state_q[i])
                    S_FETCH:   if (fetch_done[i]) state_d[i] = S_DECODE;
                    S_DECODE:  state_d[i] = S_REQUEST;
                    S_REQUEST: if (grant_valid && grant_idx == IDX_W'(i)) state_d[i] = S_WAIT;
                    S_WAIT:    if (!decoded_mem[i] || lsu_done) state_d[i] = S_EXECUTE;
                    S_EXECUTE: state_d[i] = S_UPDATE;
                    S_UPDATE: begin
                        pc_d[i]    = branch_taken ? branch_target : pc_q[i] + 1'b1;
                        state_d[i] = decoded_halt[i] ? S_DONE : S_FETCH;
                    end
                    default: ;
                endcase
            end

            if (grant_valid) begin
                cur_d   = grant_idx;
                rr_d    = grant_idx;
                valid_d = 1'b1;
            end else if (valid_q && state_q[cur_q] == S_UPDATE) begin
                valid_d = 1'b0;
            end

            if (launched_q && all_quiet) done_d = 1'b1;
        end
    end

    // Flatten per-warp registers onto the packed output buses.
    always_comb begin
        warp_state = '0;
        pc         = '0;
        for (int unsigned i = 0; i < NWARP; i++) begin
            warp_state[3*i +: 3]             = state_q[i];
            pc[PC_WIDTH*i +: PC_WIDTH]       = pc_q[i];
        end
    end

    assign current_warp  = cur_q;
    assign current_valid = valid_q;
    assign done          = done_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// tb_warp_scheduler: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the warp scheduler rules.
module tb_warp_scheduler;

    localparam int W      = 4;
    localparam int PW     = 12;
    localparam int PC_MOD = 1 << PW;

    logic            clk;
    logic            reset;
    logic            start;
    logic [2:0]      num_warps;
    logic [W-1:0]    fetch_done;
    logic [W-1:0]    decoded_mem;
    logic [W-1:0]    decoded_halt;
    logic            lsu_done;
    logic            branch_taken;
    logic [PW-1:0]   branch_target;
    logic [3*W-1:0]  warp_state;
    logic [PW*W-1:0] pc;
    logic [1:0]      current_warp;
    logic            current_valid;
    logic            done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain integers, states numbered as in the scheduler's
    // published encoding (0 idle .. 7 done).
    int m_st [W];
    int m_pc [W];
    int m_cur, m_valid, m_rr, m_done, m_launched;

    warp_scheduler #(
        .WARPS_PER_CORE   (W),
        .THREADS_PER_WARP (32),
        .PC_WIDTH         (PW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .num_warps     (num_warps),
        .fetch_done    (fetch_done),
        .decoded_mem   (decoded_mem),
        .decoded_halt  (decoded_halt),
        .lsu_done      (lsu_done),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .warp_state    (warp_state),
        .pc            (pc),
        .current_warp  (current_warp),
        .current_valid (current_valid),
        .done          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dut_state(input int i);
        return 64'(warp_state[3*i +: 3]);
    endfunction

    function automatic logic [63:0] dut_pc(input int i);
        return 64'(pc[PW*i +: PW]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            m_st[i] = 0;
            m_pc[i] = 0;
        end
        m_cur = 0; m_valid = 0; m_rr = W - 1; m_done = 0; m_launched = 0;
    endtask

    task automatic model_step();
        int  nst [W];
        int  npc [W];
        bit  quiet;
        bit  free_path;
        int  g;
        int  j;
        quiet = 1'b1;
        for (int i = 0; i < W; i++) begin
            nst[i] = m_st[i];
            npc[i] = m_pc[i];
            if (m_st[i] != 0 && m_st[i] != 7) quiet = 1'b0;
        end
        if (start && quiet) begin
            for (int i = 0; i < W; i++) begin
                nst[i] = (i < int'(num_warps)) ? 1 : 7;
                npc[i] = 0;
            end
            m_done = 0;
            m_launched = 1;
        end else begin
            free_path = (m_valid == 0) || (m_st[m_cur] == 6);
            g = -1;
            if (free_path) begin
                for (int k = 1; k <= W; k++) begin
                    j = (m_rr + k) % W;
                    if (g < 0 && m_st[j] == 3) g = j;
                end
            end
            for (int i = 0; i < W; i++) begin
                case (m_st[i])
                    1: if (fetch_done[i]) nst[i] = 2;
                    2: nst[i] = 3;
                    3: if (g == i) nst[i] = 4;
                    4: if (!decoded_mem[i] || lsu_done) nst[i] = 5;
                    5: nst[i] = 6;
                    6: begin
                        npc[i] = branch_taken ? int'(branch_target) : (m_pc[i] + 1) % PC_MOD;
                        nst[i] = decoded_halt[i] ? 7 : 1;
                    end
                    default: ;
                endcase
            end
            if (g >= 0) begin
                m_cur = g; m_rr = g; m_valid = 1;
            end else if (m_valid == 1 && m_st[m_cur] == 6) begin
                m_valid = 0;
            end
            if (m_launched == 1 && quiet) m_done = 1;
        end
        for (int i = 0; i < W; i++) begin
            m_st[i] = nst[i];
            m_pc[i] = npc[i];
        end
    endtask

    task automatic compare_all(input string where);
        logic [63:0] es;
        logic [63:0] ep;
        es = '0;
        ep = '0;
        for (int i = 0; i < W; i++) begin
            es[3*i +: 3]   = 3'(m_st[i]);
            ep[PW*i +: PW] = PW'(m_pc[i]);
        end
        check_eq({where, ".state"}, 64'(warp_state), es);
        check_eq({where, ".pc"},    64'(pc), ep);
        check_eq({where, ".valid"}, 64'(current_valid), 64'(m_valid));
        check_eq({where, ".cur"},   64'(current_warp), 64'(m_cur));
        check_eq({where, ".done"},  64'(done), 64'(m_done));
    endtask

    task automatic clear_inputs();
        start = 1'b0; num_warps = '0; fetch_done = '0; decoded_mem = '0;
        decoded_halt = '0; lsu_done = 1'b0; branch_taken = 1'b0; branch_target = '0;
    endtask

    // One clock: inputs are already stable; outputs are compared 1ns after the edge.
    task automatic step(input string where);
        @(posedge clk);
        model_step();
        #1;
        compare_all(where);
    endtask

    // Reset is raised between edges so the asynchronous clear is observed directly.
    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all("reset_async");
        @(posedge clk);
        #1;
        compare_all("reset_hold");
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        model_reset();
        #2;
        apply_reset();

        // Reset in the middle of warp 2's memory wait.
        start = 1'b1; num_warps = 3'd4;
        step("t1_start");
        start = 1'b0; fetch_done = 4'b0100; decoded_mem = 4'b0100;
        step("t1_fetch");
        fetch_done = '0;
        step("t1_decode");
        step("t1_grant");
        check_eq("t1_owner", 64'(current_warp), 64'd2);
        check_eq("t1_wait",  dut_state(2), 64'd4);
        step("t1_hold0");
        step("t1_hold1");
        apply_reset();
        check_eq("t1_rst_state", 64'(warp_state), 64'd0);
        check_eq("t1_rst_valid", 64'(current_valid), 64'd0);
        check_eq("t1_rst_pc",    64'(pc), 64'd0);
        clear_inputs();

        // Single warp, three instructions, halt on the third.
        start = 1'b1; num_warps = 3'd1;
        step("t2_start");
        check_eq("t2_launch", 64'(warp_state), 64'hFF9);
        start = 1'b0; fetch_done = 4'b0001;
        for (int n = 0; n < 3; n++) begin
            check_eq("t2_pc", dut_pc(0), 64'(n));
            decoded_halt = (n == 2) ? 4'b0001 : 4'b0000;
            repeat (6) step("t2_run");
        end
        check_eq("t2_halted", dut_state(0), 64'd7);
        check_eq("t2_pc_end", dut_pc(0), 64'd3);
        check_eq("t2_not_yet", 64'(done), 64'd0);
        step("t2_done");
        check_eq("t2_done_set", 64'(done), 64'd1);
        clear_inputs();

        // All four request together: grants 0,1,2,3 back to back.
        apply_reset();
        start = 1'b1; num_warps = 3'd4;
        step("t3_start");
        start = 1'b0; fetch_done = 4'hF; decoded_halt = 4'hF;
        step("t3_fetch");
        fetch_done = '0;
        step("t3_decode");
        step("t3_grant0");
        check_eq("t3_owner0", 64'(current_warp), 64'd0);
        for (int k = 1; k < W; k++) begin
            repeat (3) step("t3_run");
            check_eq("t3_owner", 64'(current_warp), 64'(k));
            check_eq("t3_valid", 64'(current_valid), 64'd1);
            check_eq("t3_wait",  dut_state(k), 64'd4);
        end
        repeat (3) step("t3_tail");
        check_eq("t3_released", 64'(current_valid), 64'd0);
        step("t3_done");
        check_eq("t3_done_set", 64'(done), 64'd1);
        clear_inputs();

        // Warp 0 waits on the LSU for 7 cycles; warp 1 queues behind it.
        apply_reset();
        start = 1'b1; num_warps = 3'd2;
        step("t4_start");
        start = 1'b0; fetch_done = 4'b0011; decoded_mem = 4'b0001;
        step("t4_fetch");
        fetch_done = '0;
        step("t4_decode");
        step("t4_grant");
        for (int c = 0; c < 7; c++) begin
            check_eq("t4_w0_wait", dut_state(0), 64'd4);
            check_eq("t4_w1_req",  dut_state(1), 64'd3);
            if (c == 6) lsu_done = 1'b1;
            step("t4_lsu");
        end
        lsu_done = 1'b0;
        check_eq("t4_w0_exec", dut_state(0), 64'd5);
        step("t4_update");
        step("t4_handoff");
        check_eq("t4_owner1", 64'(current_warp), 64'd1);
        check_eq("t4_w1_wait", dut_state(1), 64'd4);
        clear_inputs();

        // Branch redirect and PC wrap.
        apply_reset();
        start = 1'b1; num_warps = 3'd1;
        step("t5_start");
        start = 1'b0; fetch_done = 4'b0001;
        branch_taken = 1'b1; branch_target = 12'h040;
        repeat (6) step("t5_br");
        check_eq("t5_pc_040", dut_pc(0), 64'h040);
        branch_target = 12'hFFF;
        repeat (6) step("t5_br2");
        check_eq("t5_pc_fff", dut_pc(0), 64'hFFF);
        branch_taken = 1'b0; branch_target = 12'h123;
        repeat (6) step("t5_wrap");
        check_eq("t5_pc_wrap", dut_pc(0), 64'h000);
        clear_inputs();

        // Zero warps, oversize num_warps, start while busy.
        apply_reset();
        start = 1'b1; num_warps = 3'd0;
        step("t6_zero");
        check_eq("t6_all_done", 64'(warp_state), 64'hFFF);
        start = 1'b0;
        step("t6_done");
        check_eq("t6_done_set", 64'(done), 64'd1);
        start = 1'b1; num_warps = 3'd7;
        step("t6_seven");
        check_eq("t6_four_fetch", 64'(warp_state), 64'h249);
        check_eq("t6_done_clr", 64'(done), 64'd0);
        num_warps = 3'd1;
        step("t6_busy");
        check_eq("t6_ignored", 64'(warp_state), 64'h249);
        clear_inputs();

        // Randomized traffic.
        for (int ep = 0; ep < 6; ep++) begin
            apply_reset();
            for (int cyc = 0; cyc < 600; cyc++) begin
                start         = ($urandom_range(0, 15) == 0);
                num_warps     = 3'($urandom_range(0, 7));
                fetch_done    = 4'($urandom);
                decoded_mem   = 4'($urandom);
                decoded_halt  = 4'($urandom & $urandom & $urandom);
                lsu_done      = ($urandom_range(0, 2) == 0);
                branch_taken  = ($urandom_range(0, 3) == 0);
                branch_target = 12'($urandom);
                if ($urandom_range(0, 399) == 0) begin
                    apply_reset();
                end else begin
                    step("rand");
                end
            end
        end
        clear_inputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
